rv_regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32I core. It is the next generation of the fixed 32x32 2R1W file. It adds configurable width, depth and read-port count, plus a second write port. It also adds optional write-to-read bypass, optional registered reads and a per-register busy scoreboard for the decode/issue stage. Register x0 is hardwired to zero and is never busy.

---
 rtl/rv_pkg.sv | 18 +
 rtl/rv_scoreboard.sv | 39 +++
 rtl/rv_regfile_mp.sv | 115 +++++++++++
 tb/tb_rv_regfile_mp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: default sizes, the zero-register index and a clog2 helper.
package rv_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned REG_ZERO  = 0;

  // Number of address bits needed to index n entries (n >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Per-register busy scoreboard: alloc marks a destination busy, writeback clears it.
module rv_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = clog2(NREGS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic             alloc_en,
  input  logic [AW-1:0]    alloc_addr,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Writebacks clear first; a same-cycle alloc re-marks, since the new producer wins.
  always_comb begin
    busy_nxt = busy_q;
    if (we0) busy_nxt[waddr0] = 1'b0;
    if (we1) busy_nxt[waddr1] = 1'b0;
    if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rv_regfile_mp.sv
// Parametrised multi-port integer register file with bypass, optional registered reads and busy scoreboard.
module rv_regfile_mp
  import rv_pkg::*;
#(
  parameter  int unsigned XLEN      = XLEN_DEF,
  parameter  int unsigned NREGS     = NREGS_DEF,
  parameter  int unsigned NRD       = 2,
  parameter  int unsigned BYPASS    = 1,
  parameter  int unsigned SYNC_READ = 0,
  localparam int unsigned AW        = clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NRD*XLEN-1:0] rd_c;
  logic [NRD-1:0]      rbusy_c;
  logic [AW-1:0]       ra;
  logic [XLEN-1:0]     val;
  logic                hit0;
  logic                hit1;
  logic                rb;
  logic                wr0_ok;
  logic                wr1_ok;

  // Port 0 is dropped when port 1 targets the same register; x0 is never written.
  assign wr1_ok = we1 && (waddr1 != ZERO_ADDR);
  assign wr0_ok = we0 && (waddr0 != ZERO_ADDR) && !(we1 && (waddr1 == waddr0));

  // Register array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr0_ok) regs[waddr0] <= wdata0;
      if (wr1_ok) regs[waddr1] <= wdata1;
    end
  end

  // Per-port read mux with optional write forwarding and busy lookup.
  always_comb begin
    rd_c    = '0;
    rbusy_c = '0;
    ra      = '0;
    val     = '0;
    hit0    = 1'b0;
    hit1    = 1'b0;
    rb      = 1'b0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra   = raddr[k*AW +: AW];
      hit1 = we1 && (waddr1 == ra);
      hit0 = we0 && (waddr0 == ra);
      val  = regs[ra];
      rb   = busy_vec[ra];
      if (BYPASS != 0) begin
        if (hit1)      val = wdata1;
        else if (hit0) val = wdata0;
        if (hit0 || hit1) rb = 1'b0;
      end
      if (ra == ZERO_ADDR) begin
        val = '0;
        rb  = 1'b0;
      end
      rd_c[k*XLEN +: XLEN] = val;
      rbusy_c[k]           = rb;
    end
  end

  generate
    if (SYNC_READ != 0) begin : g_sync
      logic [NRD*XLEN-1:0] rdata_q;
      // Registered read data: address and bypass resolved at the sampling edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rd_c;
      end
      assign rdata = rdata_q;
    end else begin : g_comb
      assign rdata = rd_c;
    end
  endgenerate

  assign rbusy = rbusy_c;

  rv_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .we0        (we0),
    .waddr0     (waddr0),
    .we1        (we1),
    .waddr1     (waddr1),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Bench: combinational/bypass instance (a) and registered/no-bypass instance (b) against an array model.
module tb_rv_regfile_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk;
  logic                rst;
  logic                we0, we1, alloc_en;
  logic [AW-1:0]       waddr0, waddr1, alloc_addr;
  logic [XLEN-1:0]     wdata0, wdata1;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata_a, rdata_b;
  logic [NRD-1:0]      rbusy_a, rbusy_b;
  logic [NREGS-1:0]    busy_vec_a, busy_vec_b;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [XLEN-1:0] mem [NREGS];
  bit              bsy [NREGS];
  logic [XLEN-1:0] rq  [NRD];

  rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .SYNC_READ(0)) dut_a (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_a)
  );

  rv_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .SYNC_READ(1)) dut_b (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] rdaddr(input int k);
    return raddr[k*AW +: AW];
  endfunction

  // Expected comb read with forwarding: x0 reads zero, port 1 beats port 0, else stored value.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we1 && waddr1 == a) return wdata1;
    if (we0 && waddr0 == a) return wdata0;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
    return bsy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = bsy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mem[i] = '0;
      bsy[i] = 1'b0;
    end
    for (int k = 0; k < NRD; k++) rq[k] = '0;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0;
    waddr0 = '0; waddr1 = '0; alloc_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  // Advance one clock edge, updating the model from the inputs held at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < NRD; k++) rq[k] = (rdaddr(k) == 0) ? '0 : mem[rdaddr(k)];
      if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
      if (we0) bsy[waddr0] = 1'b0;
      if (we1) bsy[waddr1] = 1'b0;
      if (alloc_en) bsy[alloc_addr] = 1'b1;
      bsy[0] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; idle(); raddr = '0; model_reset();
    #3;
    for (int r = 0; r < NREGS; r++) begin
      set_rd(0, r); set_rd(1, NREGS - 1 - r);
      #1;
      checks++;
      if (rdata_a !== '0 || rbusy_a !== '0) begin
        errors++;
        $display("FAIL reset_read r=%0d rdata=%h rbusy=%b want 0/0", r, rdata_a, rbusy_a);
      end
    end
    checks++;
    if (busy_vec_a !== '0 || busy_vec_b !== '0 || rdata_b !== '0) begin
      errors++;
      $display("FAIL reset_state busy_a=%h busy_b=%h rdata_b=%h want 0", busy_vec_a, busy_vec_b, rdata_b);
    end
    @(negedge clk); rst = 0; raddr = '0;
  endtask

  task automatic test_write_read();
    idle(); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    tick();
    idle(); set_rd(0, 5); set_rd(1, 0); #1;
    checks++;
    if (rdata_a[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_x5 got=%h want=deadbeef", rdata_a[31:0]);
    end
    we0 = 1; waddr0 = 0; wdata0 = 32'h1234;
    tick();
    checks++;
    if (rdata_b[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sync_x5 got=%h want=deadbeef", rdata_b[31:0]);
    end
    idle(); set_rd(0, 0); set_rd(1, 0); #1;
    checks++;
    if (rdata_a !== '0) begin
      errors++; $display("FAIL read_x0 got=%h want=0", rdata_a);
    end
  endtask

  task automatic test_dual_write();
    idle(); we0 = 1; we1 = 1; waddr0 = 7; waddr1 = 7; wdata0 = 32'h11; wdata1 = 32'h22;
    tick();
    idle(); set_rd(0, 7); #1;
    checks++;
    if (rdata_a[31:0] !== 32'h22) begin
      errors++; $display("FAIL same_addr_x7 got=%h want=22", rdata_a[31:0]);
    end
    we0 = 1; we1 = 1; waddr0 = 3; waddr1 = 4; wdata0 = 32'h33; wdata1 = 32'h44;
    tick();
    idle(); set_rd(0, 3); set_rd(1, 4); #1;
    checks++;
    if (rdata_a !== {32'h44, 32'h33}) begin
      errors++; $display("FAIL diff_addr_x3_x4 got=%h want=%h", rdata_a, {32'h44, 32'h33});
    end
    tick();
    checks++;
    if (rdata_b !== {32'h44, 32'h33}) begin
      errors++; $display("FAIL sync_x3_x4 got=%h want=%h", rdata_b, {32'h44, 32'h33});
    end
  endtask

  task automatic test_bypass();
    idle(); set_rd(0, 9); set_rd(1, 0);
    we0 = 1; waddr0 = 9; wdata0 = 32'hA5A5A5A5; #1;
    checks++;
    if (rdata_a[31:0] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_x9 got=%h want=a5a5a5a5", rdata_a[31:0]);
    end
    tick();
    checks++;
    if (rdata_b[31:0] !== 32'h0) begin
      errors++; $display("FAIL nobypass_old_x9 got=%h want=0", rdata_b[31:0]);
    end
    idle(); tick();
    checks++;
    if (rdata_b[31:0] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL sync_new_x9 got=%h want=a5a5a5a5", rdata_b[31:0]);
    end
  endtask

  task automatic test_sync_read();
    idle(); raddr = '0; we1 = 1; waddr1 = 20; wdata1 = 32'h13579BDF;
    tick();
    idle(); set_rd(1, 20); #1;
    checks++;
    if (rdata_b[63:32] !== 32'h0) begin
      errors++; $display("FAIL sync_before_edge got=%h want=0", rdata_b[63:32]);
    end
    tick();
    checks++;
    if (rdata_b[63:32] !== 32'h13579BDF) begin
      errors++; $display("FAIL sync_after_edge got=%h want=13579bdf", rdata_b[63:32]);
    end
    alloc_en = 1; alloc_addr = 6;
    tick();
    idle();
    rst = 1; model_reset(); #1;
    checks++;
    if (rdata_b !== '0 || busy_vec_a !== '0 || rdata_a[63:32] !== '0) begin
      errors++;
      $display("FAIL mid_reset rdata_b=%h busy=%h rdata_a=%h want 0", rdata_b, busy_vec_a, rdata_a);
    end
    we0 = 1; waddr0 = 21; wdata0 = 32'hCAFEF00D;
    tick();
    rst = 0; idle(); set_rd(0, 21); #1;
    checks++;
    if (rdata_a[31:0] !== 32'h0) begin
      errors++; $display("FAIL reset_drops_write got=%h want=0", rdata_a[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); raddr = '0; alloc_en = 1; alloc_addr = 12;
    tick();
    idle(); set_rd(0, 12); #1;
    checks++;
    if (busy_vec_a[12] !== 1'b1 || busy_vec_a !== exp_vec()) begin
      errors++; $display("FAIL alloc_x12 busy=%h want=%h", busy_vec_a, exp_vec());
    end
    checks++;
    if (rbusy_a[0] !== 1'b1 || rbusy_b[0] !== 1'b1) begin
      errors++; $display("FAIL rbusy_x12 a=%b b=%b want 1/1", rbusy_a[0], rbusy_b[0]);
    end
    we1 = 1; waddr1 = 12; wdata1 = 32'h77; #1;
    checks++;
    if (rbusy_a[0] !== 1'b0 || rbusy_b[0] !== 1'b1) begin
      errors++; $display("FAIL rbusy_wb_x12 a=%b b=%b want 0/1", rbusy_a[0], rbusy_b[0]);
    end
    tick();
    idle(); #1;
    checks++;
    if (busy_vec_a[12] !== 1'b0) begin
      errors++; $display("FAIL clear_x12 busy=%b want 0", busy_vec_a[12]);
    end
    alloc_en = 1; alloc_addr = 12; we0 = 1; waddr0 = 12; wdata0 = 32'h88;
    tick();
    idle(); #1;
    checks++;
    if (busy_vec_a[12] !== 1'b1) begin
      errors++; $display("FAIL alloc_and_write_x12 busy=%b want 1", busy_vec_a[12]);
    end
    alloc_en = 1; alloc_addr = 0;
    tick();
    idle(); #1;
    checks++;
    if (busy_vec_a[0] !== 1'b0 || busy_vec_b[0] !== 1'b0) begin
      errors++; $display("FAIL alloc_x0 busy0=%b/%b want 0", busy_vec_a[0], busy_vec_b[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(1, 0)); we1 = 1'($urandom_range(1, 0));
      alloc_en = 1'($urandom_range(1, 0));
      waddr0 = AW'($urandom_range(7, 0)); waddr1 = AW'($urandom_range(7, 0));
      alloc_addr = AW'($urandom_range(7, 0));
      wdata0 = $urandom; wdata1 = $urandom;
      for (int k = 0; k < NRD; k++) set_rd(k, int'($urandom_range(7, 0)));
      if (n % 9 == 0) set_rd(0, int'($urandom_range(NREGS - 1, 0)));
      #1;
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rdata_a[k*XLEN +: XLEN] !== exp_rd(rdaddr(k))) begin
          errors++;
          $display("FAIL rand_rdata n=%0d k=%0d a=%0d got=%h want=%h", n, k, rdaddr(k),
                   rdata_a[k*XLEN +: XLEN], exp_rd(rdaddr(k)));
        end
        checks++;
        if (rdata_b[k*XLEN +: XLEN] !== rq[k]) begin
          errors++;
          $display("FAIL rand_sync n=%0d k=%0d got=%h want=%h", n, k, rdata_b[k*XLEN +: XLEN], rq[k]);
        end
        checks++;
        if (rbusy_a[k] !== exp_busy(rdaddr(k), 1) || rbusy_b[k] !== exp_busy(rdaddr(k), 0)) begin
          errors++;
          $display("FAIL rand_rbusy n=%0d k=%0d got=%b/%b want=%b/%b", n, k, rbusy_a[k], rbusy_b[k],
                   exp_busy(rdaddr(k), 1), exp_busy(rdaddr(k), 0));
        end
      end
      checks++;
      if (busy_vec_a !== exp_vec() || busy_vec_b !== exp_vec()) begin
        errors++;
        $display("FAIL rand_busy_vec n=%0d got=%h/%h want=%h", n, busy_vec_a, busy_vec_b, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    raddr = '0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_bypass();
    test_sync_read();
    test_scoreboard();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
